// File: rtl/oh_fifo_sync_prog.sv
// Single-clock FIFO with occupancy count, programmable thresholds, sticky error flags,
// synchronous flush and write-through on full. Define OH_FIFO_FWFT_EN for first-word fall-through.
module oh_fifo_sync_prog #(
  parameter int DW         = 64,
  parameter int DEPTH      = 32,
  parameter int PROG_FULL  = DEPTH - 4,
  parameter int PROG_EMPTY = 2,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          full,
  output logic          prog_full,
  output logic          prog_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] LP_DEPTH      = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_PROG_FULL  = (AW+1)'(PROG_FULL);
  localparam logic [AW:0] LP_PROG_EMPTY = (AW+1)'(PROG_EMPTY);
  localparam logic [AW:0] LP_ONE        = (AW+1)'(1);

  if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("oh_fifo_sync_prog: DEPTH must be a power of two >= 4");
  end
  if (PROG_FULL < 1 || PROG_FULL > DEPTH) begin : g_bad_prog_full
    $error("oh_fifo_sync_prog: PROG_FULL out of range 1..DEPTH");
  end
  if (PROG_EMPTY < 0 || PROG_EMPTY > DEPTH - 1) begin : g_bad_prog_empty
    $error("oh_fifo_sync_prog: PROG_EMPTY out of range 0..DEPTH-1");
  end

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_prog_full;
  logic          r_prog_empty;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_rd_acc;
  logic          w_wr_acc;
  logic          w_mem_we;
  logic [AW:0]   w_count_nxt;

  // A read frees a slot in the same edge, so a full FIFO can still take a write.
  assign w_rd_acc = rd_en & ~r_empty;
  assign w_wr_acc = wr_en & (~r_full | w_rd_acc);
  // Gating on nreset keeps a write from landing while reset is held.
  assign w_mem_we = w_wr_acc & ~clear & nreset;

  always_comb begin
    w_count_nxt = r_count;
    if (clear) begin
      w_count_nxt = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + LP_ONE;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - LP_ONE;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_prog_full  <= 1'b0;
      r_prog_empty <= 1'b1;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_empty      <= (w_count_nxt == '0);
      r_full       <= (w_count_nxt == LP_DEPTH);
      r_prog_full  <= (w_count_nxt >= LP_PROG_FULL);
      r_prog_empty <= (w_count_nxt <= LP_PROG_EMPTY);
      if (clear) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + LP_ONE;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + LP_ONE;
        if (wr_en && !w_wr_acc) r_overflow  <= 1'b1;
        if (rd_en && !w_rd_acc) r_underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

`ifdef OH_FIFO_FWFT_EN
  // Head word is presented combinationally; rd_en only acknowledges it.
  assign dout       = r_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign dout_valid = ~r_empty;
`else
  logic [DW-1:0] r_dout;
  logic          r_dout_valid;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_acc & ~clear;
      if (w_rd_acc && !clear) r_dout <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
`endif

  assign empty      = r_empty;
  assign full       = r_full;
  assign prog_full  = r_prog_full;
  assign prog_empty = r_prog_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_oh_fifo_sync_prog.sv
// Directed bench for oh_fifo_sync_prog (standard registered-read build), DEPTH=8, DW=16.
module tb_oh_fifo_sync_prog;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          nreset;
  logic          clear;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          empty;
  logic          full;
  logic          prog_full;
  logic          prog_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int n_total;
  int n_pass;

  oh_fifo_sync_prog #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .clear      (clear),
    .wr_en      (wr_en),
    .din        (din),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .empty      (empty),
    .full       (full),
    .prog_full  (prog_full),
    .prog_empty (prog_empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    wr_en = w;
    din   = d;
    rd_en = r;
    clear = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic fill(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + DW'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_pempty"}, 32'(prog_empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_pfull"}, 32'(prog_full), 0);
    chk({tag, "_dout"}, 32'(dout), 0);
    chk({tag, "_dvalid"}, 32'(dout_valid), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_udf"}, 32'(underflow), 0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    drive(1'b0, '0, 1'b0, 1'b0);
    nreset = 1'b1;
    #1 nreset = 1'b0;
    #1;
    chk_reset_state("rst");
    tick();
    tick();
    nreset = 1'b1;

    // 1: fill 1..8 then drain
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      tick();
      chk($sformatf("fill_count%0d", i), 32'(count), 32'(i));
      chk($sformatf("fill_pfull%0d", i), 32'(prog_full), 32'(i >= 4));
      chk($sformatf("fill_pempty%0d", i), 32'(prog_empty), 32'(i <= 2));
      chk($sformatf("fill_full%0d", i), 32'(full), 32'(i == DEPTH));
      chk($sformatf("fill_empty%0d", i), 32'(empty), 0);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk($sformatf("drain_dout%0d", i), 32'(dout), 32'(i));
      chk($sformatf("drain_dvalid%0d", i), 32'(dout_valid), 1);
      chk($sformatf("drain_count%0d", i), 32'(count), 32'(DEPTH - i));
    end
    chk("drain_empty", 32'(empty), 1);
    idle();
    chk("hold_dvalid", 32'(dout_valid), 0);
    chk("hold_dout", 32'(dout), 32'h0008);
    chk("hold_udf", 32'(underflow), 0);

    // 2: write-through on full
    fill(16'h0011, DEPTH);
    chk("wt_pre_full", 32'(full), 1);
    drive(1'b1, 16'hAAAA, 1'b1, 1'b0);
    tick();
    chk("wt_count", 32'(count), 8);
    chk("wt_full", 32'(full), 1);
    chk("wt_ovf", 32'(overflow), 0);
    chk("wt_dout", 32'(dout), 32'h0011);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk($sformatf("wt_drain%0d", i), 32'(dout), (i == DEPTH - 1) ? 32'hAAAA : 32'h0012 + 32'(i));
    end
    chk("wt_empty", 32'(empty), 1);

    // 3: overflow, underflow, clear
    fill(16'h0021, DEPTH);
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
    tick();
    chk("ovf_count", 32'(count), 8);
    chk("ovf_set", 32'(overflow), 1);
    idle();
    chk("ovf_sticky", 32'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk($sformatf("ovf_drain%0d", i), 32'(dout), 32'h0021 + 32'(i));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("udf_set", 32'(underflow), 1);
    chk("udf_dvalid", 32'(dout_valid), 0);
    chk("udf_count", 32'(count), 0);
    chk("udf_ovf_kept", 32'(overflow), 1);
    fill(16'h0031, 3);
    drive(1'b1, 16'h7777, 1'b1, 1'b1);
    tick();
    chk("clr_count", 32'(count), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_pempty", 32'(prog_empty), 1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);
    chk("clr_dvalid", 32'(dout_valid), 0);
    chk("clr_dout_hold", 32'(dout), 32'h0028);

    // 4: steady write+read at count=3 across pointer wrap
    fill(16'h0100, 3);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'h0103 + DW'(i), 1'b1, 1'b0);
      tick();
      chk($sformatf("wrap_count%0d", i), 32'(count), 3);
      chk($sformatf("wrap_dout%0d", i), 32'(dout), 32'h0100 + 32'(i));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      chk($sformatf("wrap_tail%0d", i), 32'(dout), 32'h0114 + 32'(i));
    end
    chk("wrap_empty", 32'(empty), 1);
    chk("wrap_udf", 32'(underflow), 0);

    // 5: write+read on empty
    drive(1'b1, 16'h5555, 1'b1, 1'b0);
    tick();
    chk("er_count", 32'(count), 1);
    chk("er_udf", 32'(underflow), 1);
    chk("er_dvalid", 32'(dout_valid), 0);
    chk("er_empty", 32'(empty), 0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("er_dout", 32'(dout), 32'h5555);
    chk("er_dvalid2", 32'(dout_valid), 1);
    chk("er_count2", 32'(count), 0);

    // 6: reset mid-burst
    fill(16'h0600, 2);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h0999, 1'b0, 1'b0);
    nreset = 1'b0;
    #1;
    chk_reset_state("mid");
    tick();
    chk("mid_held_count", 32'(count), 0);
    nreset = 1'b1;
    drive(1'b1, 16'h0C0D, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("post_rst_dout", 32'(dout), 32'h0C0D);
    chk("post_rst_empty", 32'(empty), 1);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
